// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle MIPS multiply/divide unit with HI/LO registers (optional MD_CANCEL_EN adds cancel input)
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef MD_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic             en,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             is_md,
  output logic             busy,
  output logic             stall_req,
  output logic             mf_we,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [7:0]       MUL_N    = 8'(MUL_CYCLES);
  localparam logic [7:0]       DIV_N    = 8'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic             cancel_i;
  logic             is_mul, is_div, is_mf, is_mt;
  logic             accept, issue;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;

`ifdef MD_CANCEL_EN
  assign cancel_i = cancel;
`else
  assign cancel_i = 1'b0;
`endif

  always_comb begin
    is_mul = (opcode == 6'd0) && (funct == F_MULT || funct == F_MULTU);
    is_div = (opcode == 6'd0) && (funct == F_DIV  || funct == F_DIVU);
    is_mf  = (opcode == 6'd0) && (funct == F_MFHI || funct == F_MFLO);
    is_mt  = (opcode == 6'd0) && (funct == F_MTHI || funct == F_MTLO);
    is_md  = is_mul | is_div | is_mf | is_mt;
  end

  assign accept = en & is_md & ~busy & ~cancel_i;
  assign issue  = accept & (is_mul | is_div);

  // Zero-divisor and signed-overflow cases are resolved before the divider so it never sees them.
  always_comb begin
    prod   = '0;
    res_hi = '0;
    res_lo = '0;
    if (is_mul) begin
      if (funct == F_MULT)
        prod = {{WIDTH{rs_val[WIDTH-1]}}, rs_val} * {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
      else
        prod = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (rt_val == '0) begin
      res_lo = '1;
      res_hi = rs_val;
    end else if (funct == F_DIV && rs_val == MOST_NEG && rt_val == '1) begin
      res_lo = MOST_NEG;
      res_hi = '0;
    end else if (funct == F_DIV) begin
      res_lo = $signed(rs_val) / $signed(rt_val);
      res_hi = $signed(rs_val) % $signed(rt_val);
    end else begin
      res_lo = rs_val / rt_val;
      res_hi = rs_val % rt_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = BUSY;
      BUSY:    if (cancel_i || cnt_q == 8'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == BUSY);
    stall_req = en & is_md & busy;
    mf_we     = accept & is_mf;
    rdata     = '0;
    if (mf_we) rdata = (funct == F_MFHI) ? hi_q : lo_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else if (state_q == IDLE) begin
      if (issue) begin
        pend_hi_q <= res_hi;
        pend_lo_q <= res_lo;
        cnt_q     <= is_mul ? MUL_N : DIV_N;
      end else if (accept && is_mt) begin
        if (funct == F_MTHI) hi_q <= rs_val;
        else                 lo_q <= rs_val;
      end
    end else begin
      // Cancel outranks the final count: the pending result is dropped.
      if (cancel_i) begin
        cnt_q <= '0;
      end else if (cnt_q == 8'd1) begin
        hi_q  <= pend_hi_q;
        lo_q  <= pend_lo_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed table-driven bench for md_unit (MD_CANCEL_EN enables cancel sequence)
module tb_md_unit;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
`ifdef MD_CANCEL_EN
  logic        cancel = 1'b0;
`endif
  logic        is_md, busy, stall_req, mf_we;
  logic [31:0] rdata, hi, lo;

  md_unit dut (
    .clk(clk), .reset_n(reset_n),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .en(en), .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
    .is_md(is_md), .busy(busy), .stall_req(stall_req), .mf_we(mf_we),
    .rdata(rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int stalls;
    int bad_we;

    vecs[0]  = '{F_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[2]  = '{F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 10};
    vecs[3]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[4]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[5]  = '{F_DIV,   32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 10};
    vecs[6]  = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{F_MULT,  32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 5};
    vecs[8]  = '{F_DIVU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF, 10};
    vecs[9]  = '{F_MTHI,  32'h00001234, 32'h00000000, 32'h00001234, 32'h7FFFFFFF, 0};
    vecs[10] = '{F_MTLO,  32'h0000ABCD, 32'h00000000, 32'h00001234, 32'h0000ABCD, 0};

    repeat (2) tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      funct = vecs[i].fn; rs_val = vecs[i].rs; rt_val = vecs[i].rt; en = 1'b1;
      tick();
      en = 1'b0; rs_val = 32'hDEADBEEF; rt_val = 32'h5A5A5A5A;
      wait_idle(n);
      check($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // MULTU followed by MFLO: held for the whole busy window
    funct = F_MULTU; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF; en = 1'b1;
    tick();
    funct = F_MFLO; rs_val = '0;
    #1;
    stalls = 0; bad_we = 0;
    while (stall_req && stalls < 300) begin
      if (mf_we) bad_we++;
      stalls++;
      tick();
    end
    check("mflo_stall_cycles", 32'(stalls), 32'd5);
    check("mflo_we_during_stall", 32'(bad_we), 32'd0);
    check("mflo_we", {31'd0, mf_we}, 32'd1);
    check("mflo_rdata", rdata, 32'h00000001);
    check("multu_hi", hi, 32'hFFFFFFFE);
    en = 1'b0;
    #1;
    check("rdata_idle_zero", rdata, 32'd0);
    tick();

    // MTHI then MFHI back-to-back
    funct = F_MTHI; rs_val = 32'h00001234; en = 1'b1;
    #1;
    check("mthi_stall", {31'd0, stall_req}, 32'd0);
    tick();
    funct = F_MFHI; rs_val = '0;
    #1;
    check("mfhi_stall", {31'd0, stall_req}, 32'd0);
    check("mfhi_we", {31'd0, mf_we}, 32'd1);
    check("mfhi_rdata", rdata, 32'h00001234);
    en = 1'b0;
    tick();

    // Non-HI/LO instruction while busy
    funct = F_MULT; rs_val = 32'd2; rt_val = 32'd3; en = 1'b1;
    tick();
    funct = F_ADDU;
    #1;
    check("addu_busy", {31'd0, busy}, 32'd1);
    check("addu_stall", {31'd0, stall_req}, 32'd0);
    check("addu_is_md", {31'd0, is_md}, 32'd0);
    opcode = 6'h23; funct = F_MULT;
    #1;
    check("nonzero_opcode_is_md", {31'd0, is_md}, 32'd0);
    opcode = '0; en = 1'b0;
    wait_idle(n);
    check("mult_small_lo", lo, 32'd6);

    // Asynchronous reset three cycles into a DIV
    funct = F_DIV; rs_val = 32'd100; rt_val = 32'd7; en = 1'b1;
    tick();
    en = 1'b0;
    tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_hi", hi, 32'd0);
    check("areset_lo", lo, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (12) tick();
    check("areset_no_commit_lo", lo, 32'd0);

`ifdef MD_CANCEL_EN
    funct = F_MTHI; rs_val = 32'h55; en = 1'b1;
    tick();
    funct = F_MTLO; rs_val = 32'h66;
    tick();
    funct = F_MULT; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    en = 1'b0;
    tick(); tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_hi", hi, 32'h55);
    check("cancel_lo", lo, 32'h66);
    repeat (8) tick();
    check("cancel_no_commit_lo", lo, 32'h66);
    funct = F_MTHI; rs_val = 32'h77; en = 1'b1; cancel = 1'b1;
    tick();
    en = 1'b0; cancel = 1'b0;
    check("cancel_idle_mthi", hi, 32'h55);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
